// File: rtl/probe_pkg.sv
// Shared types and defaults for the path delay probe sequencer.
package probe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int SETTLE_CYC_DEF  = 32;
  localparam int SYNC_STAGES_DEF = 2;

  // Trial direction is the level path_launch moves to at the launch edge.
  localparam logic DIR_RISE = 1'b1;
  localparam logic DIR_FALL = 1'b0;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer bringing the asynchronous chain output into clk.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/path_delay_probe_ctrl.sv
// Launch/capture sequencer: toggles the chain input, samples the chain output
// a programmable number of cycles later and counts rising/falling arrivals.
module path_delay_probe_ctrl
  import probe_pkg::*;
#(
  parameter int WAIT_W      = 8,
  parameter int TRIALS_W    = 8,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WAIT_W-1:0]   cfg_wait,
  input  logic [TRIALS_W-1:0] cfg_trials,
  output logic                path_launch,
  input  logic                path_capture,
  output logic                busy,
  output logic                done,
  output logic [TRIALS_W-1:0] rise_match,
  output logic [TRIALS_W-1:0] fall_match,
  output state_t              dbg_state_o
);

  localparam int TMR_W = $clog2(SETTLE_CYC + (1 << WAIT_W) + SYNC_STAGES + 1);
  localparam logic [TMR_W-1:0] SETTLE_END = TMR_W'(SETTLE_CYC - 1);

  state_t              state_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [TRIALS_W-1:0] trials_q;
  logic [TRIALS_W-1:0] trial_q;
  logic [TMR_W-1:0]    tmr_q;
  logic                dir_q;
  logic                sample;
  logic [TMR_W-1:0]    wait_end;
  logic [TRIALS_W-1:0] trial_nx;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (path_capture),
    .q_o    (sample)
  );

  // WAIT covers cfg_wait plus the synchronizer latency, so cfg_wait=0 still
  // compares the first sample that could have seen the launched edge.
  assign wait_end = TMR_W'(wait_q) + TMR_W'(SYNC_STAGES - 1);
  assign trial_nx = trial_q + TRIALS_W'(1);
  assign dbg_state_o = state_q;

  // start/abort are sampled every edge: start is honoured only in IDLE (a
  // busy start is dropped, never queued); abort wins in any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      trials_q    <= '0;
      trial_q     <= '0;
      tmr_q       <= '0;
      dir_q       <= DIR_FALL;
      path_launch <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rise_match  <= '0;
      fall_match  <= '0;
    end else if (abort && state_q != ST_IDLE) begin
      state_q     <= ST_IDLE;
      path_launch <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            wait_q      <= cfg_wait;
            trials_q    <= cfg_trials;
            trial_q     <= '0;
            tmr_q       <= '0;
            rise_match  <= '0;
            fall_match  <= '0;
            path_launch <= 1'b0;
            busy        <= 1'b1;
            if (cfg_trials == '0) begin
              state_q <= ST_DONE;
              done    <= 1'b1;
            end else begin
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (tmr_q == SETTLE_END) begin
            state_q <= ST_LAUNCH;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_LAUNCH: begin
          path_launch <= ~path_launch;
          dir_q       <= ~path_launch;
          tmr_q       <= '0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tmr_q == wait_end) begin
            state_q <= ST_CAPTURE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (dir_q == DIR_RISE && sample) begin
            rise_match <= rise_match + TRIALS_W'(1);
          end
          if (dir_q == DIR_FALL && !sample) begin
            fall_match <= fall_match + TRIALS_W'(1);
          end
          trial_q <= trial_nx;
          tmr_q   <= '0;
          if (trial_nx == trials_q) begin
            state_q <= ST_DONE;
            done    <= 1'b1;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_delay_probe_ctrl.sv
// Directed bench for path_delay_probe_ctrl with a delay-chain model and a
// per-cycle timeline model of the expected outputs.
module tb_path_delay_probe_ctrl;
  import probe_pkg::*;

  localparam int WAIT_W   = 8;
  localparam int TRIALS_W = 8;
  localparam int SETTLE   = 32;
  localparam int SYNC     = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [WAIT_W-1:0]   cfg_wait = '0;
  logic [TRIALS_W-1:0] cfg_trials = '0;
  logic                path_launch;
  logic                path_capture = 1'b0;
  logic                busy;
  logic                done;
  logic [TRIALS_W-1:0] rise_match;
  logic [TRIALS_W-1:0] fall_match;
  state_t              dbg_state;

  path_delay_probe_ctrl #(
    .WAIT_W(WAIT_W), .TRIALS_W(TRIALS_W), .SETTLE_CYC(SETTLE), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_wait(cfg_wait), .cfg_trials(cfg_trials),
    .path_launch(path_launch), .path_capture(path_capture),
    .busy(busy), .done(done), .rise_match(rise_match), .fall_match(fall_match),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // ---------------- delay chain model (transport delay per direction) ----------------
  int   d_rise = 5;
  int   d_fall = 5;
  logic last_l = 1'b0;
  logic pend_v = 1'b0;
  int   pend_at = -1;
  int   toggles = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (path_launch !== last_l) begin
      last_l  = path_launch;
      pend_v  = path_launch;
      pend_at = cyc + (path_launch ? d_rise : d_fall);
      toggles++;
    end
    if (cyc == pend_at) path_capture = pend_v;
  end

  // ---------------- timeline model ----------------
  // m_s is the cycle index of the accepting edge; m_ab the edge that samples abort.
  bit m_act = 1'b0;
  int m_s = 0, m_n = 0, m_w = 0, m_ab = 1 << 30, m_dr = 0, m_df = 0;

  always @(negedge clk) begin
    int c, t, ce, nl, er, ef, eb, ed, el;
    if (chk_en) begin
      eb = 0; ed = 0; el = 0; er = 0; ef = 0;
      if (m_act) begin
        c  = cyc - m_s;
        t  = SETTLE + 1 + m_w + SYNC + 1;
        ce = (cyc >= m_ab) ? (m_ab - m_s - 1) : c;
        if (cyc < m_ab) begin
          eb = (c <= m_n * t) ? 1 : 0;
          ed = (c == m_n * t) ? 1 : 0;
          nl = 0;
          for (int k = 0; k < m_n; k++) if (k * t + SETTLE + 1 <= c) nl++;
          el = nl % 2;
        end
        for (int k = 0; k < m_n; k++) begin
          if ((k + 1) * t <= ce) begin
            if (k % 2 == 0) er += (m_w >= m_dr) ? 1 : 0;
            else            ef += (m_w >= m_df) ? 1 : 0;
          end
        end
      end
      check("busy", int'(busy), eb);
      check("done", int'(done), ed);
      check("path_launch", int'(path_launch), el);
      check("rise_match", int'(rise_match), er);
      check("fall_match", int'(fall_match), ef);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_start(input int w, input int n);
    cfg_wait   = WAIT_W'(w);
    cfg_trials = TRIALS_W'(n);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_act = 1'b1; m_s = cyc; m_w = w; m_n = n; m_ab = 1 << 30;
    m_dr = d_rise; m_df = d_fall;
  endtask

  task automatic advance_to(input int c_target);
    while (cyc - m_s < c_target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - m_s + 1;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic to_drive_phase();
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  int lat;
  int done_seen;
  int exp_r[13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  int exp_f[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_busy", int'(busy), 0);
    check("reset_launch", int'(path_launch), 0);
    check("reset_rise", int'(rise_match), 0);
    chk_en = 1'b1;
    repeat (2) to_drive_phase();

    // Reset while waiting for a capture.
    d_rise = 5; d_fall = 5;
    run_start(10, 4);
    advance_to(40);
    check("pre_reset_launch", int'(path_launch), 1);
    rst_n = 1'b0;
    m_act = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_launch", int'(path_launch), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) to_drive_phase();
    check("post_reset_busy", int'(busy), 0);

    // 5-cycle chain, wait 10: every capture sees the new level.
    run_start(10, 4);
    wait_done(400, lat);
    check("lat_w10", lat, 185);
    check("rise_w10", int'(rise_match), 2);
    check("fall_w10", int'(fall_match), 2);
    repeat (3) to_drive_phase();

    // Same chain, wait 1: every capture is too early.
    toggles = 0;
    run_start(1, 4);
    wait_done(400, lat);
    check("lat_w1", lat, 149);
    check("rise_w1", int'(rise_match), 0);
    check("fall_w1", int'(fall_match), 0);
    repeat (3) to_drive_phase();
    check("toggles_w1", toggles, 4);

    // Asymmetric chain sweep.
    d_rise = 5; d_fall = 9;
    for (int w = 0; w <= 12; w++) begin
      run_start(w, 2);
      wait_done(300, lat);
      check($sformatf("sweep_rise_w%0d", w), int'(rise_match), exp_r[w]);
      check($sformatf("sweep_fall_w%0d", w), int'(fall_match), exp_f[w]);
      repeat (12) to_drive_phase();
    end

    // Zero trials.
    toggles = 0;
    run_start(5, 0);
    wait_done(10, lat);
    check("lat_n0", lat, 1);
    check("rise_n0", int'(rise_match), 0);
    check("fall_n0", int'(fall_match), 0);
    repeat (5) to_drive_phase();
    check("toggles_n0", toggles, 0);

    // Abort in trial 3 of 8 with an ignored start during trial 2.
    d_rise = 5; d_fall = 5;
    repeat (12) to_drive_phase();
    run_start(10, 8);
    advance_to(49);
    cfg_wait = '0; cfg_trials = TRIALS_W'(1); start = 1'b1;
    to_drive_phase();
    start = 1'b0;
    advance_to(130);
    abort = 1'b1;
    to_drive_phase();
    abort = 1'b0;
    m_ab = cyc;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_launch", int'(path_launch), 0);
    check("abort_rise", int'(rise_match), 1);
    check("abort_fall", int'(fall_match), 1);
    done_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_state", int'(dbg_state), int'(ST_IDLE));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/path_delay_probe_ctrl.md
Name: path_delay_probe_ctrl

Overview:
- Launch/capture sequencer for one delay-chain instance under test (e.g. a 100-stage single-path chain).
- Drives the chain input with alternating transitions and samples the chain output a programmable number of clock cycles after each launch.
- Counts, separately for rising and falling launches, how many captures had already reached the launched level.
- Software sweeps cfg_wait to find the chain's delay bin and compares it against a golden chip to flag Trojan-induced extra delay.

Parameters:
- WAIT_W, 8, width of cfg_wait (capture offset in cycles).
- TRIALS_W, 8, width of cfg_trials and of both match counters.
- SETTLE_CYC, 32, idle cycles with a stable launch level before each launch; must be at least 1.
- SYNC_STAGES, 2, flops in the path_capture synchronizer; must be at least 2.

Ports:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begins a run when idle; ignored while busy.
- abort, in, 1, terminates a run.
- cfg_wait, in, WAIT_W, capture offset; latched at start.
- cfg_trials, in, TRIALS_W, number of launches; latched at start.
- path_launch, out, 1, drives the chain input (pathInput).
- path_capture, in, 1, chain output (pathResult); asynchronous to clk.
- busy, out, 1, high from the cycle after an accepted start until the cycle after done or abort.
- done, out, 1, single-cycle pulse at the end of a run.
- rise_match, out, TRIALS_W, captures equal to 1 after a rising launch.
- fall_match, out, TRIALS_W, captures equal to 0 after a falling launch.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE. All outputs 0, synchronizer flops 0, all counters 0.
- States: IDLE, SETTLE, LAUNCH, WAIT, CAPTURE, DONE.
- IDLE, start=1: latch cfg_wait and cfg_trials; clear rise_match, fall_match and the trial counter; force path_launch=0; go to SETTLE. Exception: if cfg_trials=0, go directly to DONE.
- SETTLE: stays exactly SETTLE_CYC cycles, then LAUNCH.
- LAUNCH: one cycle. path_launch toggles at the closing edge E0. Trials alternate rise, fall, rise, ...; trial 1 is always rising. Go to WAIT.
- WAIT/CAPTURE timing:
  - The comparison uses the last synchronizer flop as registered at edge E0+cfg_wait+SYNC_STAGES.
  - CAPTURE is the cycle after that edge.
  - cfg_wait=0 gives the minimum offset, SYNC_STAGES cycles.
- CAPTURE: one cycle.
  - Rising trial and sample=1: rise_match increments.
  - Falling trial and sample=0: fall_match increments.
  - Trial counter increments. Go to DONE if the trial counter now equals the latched trials, else SETTLE.
- DONE: done=1 for one cycle, busy=1 during DONE, then IDLE. Counters hold until the next accepted start.
- Counters cannot overflow: each is at most cfg_trials.
- abort=1 in any non-IDLE state:
  - Next state IDLE, path_launch=0, no done pulse.
  - Counters hold their partial values.
  - abort has priority over every other transition, including DONE.
  - abort in IDLE has no effect.
- start while busy: ignored; it does not queue.
- Simultaneous start and abort in IDLE: start is accepted.
- path_launch is registered (glitch-free) and changes only in LAUNCH, or to 0 at start/abort.
- Run length with N=cfg_trials, N>0: N*(SETTLE_CYC+1+cfg_wait+SYNC_STAGES+1)+1 cycles from the accepted start edge to done high.
- cfg_trials=0: done is high the cycle after start; both counters read 0.

Decomposition:
- Shared package probe_pkg:
  - state enum.
  - Default constants for SETTLE_CYC and SYNC_STAGES.
  - Trial-direction encoding (RISE=1, FALL=0).
- One natural sub-module: sync_bit, an SYNC_STAGES-deep flop chain with asynchronous active-low reset to 0. The sequencer FSM and counters stay in the top module.

Test Plan:
- Reset mid-WAIT (rst_n low for 3 cycles) -> all outputs 0 immediately. After release, busy stays 0 until the next start.
- Chain modeled as a 5-cycle transport delay; cfg_wait=10, cfg_trials=4 -> rise_match=2, fall_match=2. done high exactly 4*(32+1+10+2+1)+1=185 cycles after start.
- Same model, cfg_wait=1 -> rise_match=0, fall_match=0. path_launch toggles 4 times.
- Model with rise delay 5 and fall delay 9; sweep cfg_wait=0..12, cfg_trials=2. Expected results:
  - rise_match first reaches 1 at the smallest cfg_wait whose sample edge follows rise-delay arrival; fall_match lags by 4.
  - Derive the exact cfg_wait from the bench's modeled arrival vs. sync sampling.
- cfg_trials=0 -> done one cycle after start, counters 0, path_launch never toggles.
- abort during trial 3 of 8, plus start pulsed while busy -> busy drops the cycle after abort, no done pulse, path_launch=0. Counters hold the values from trials 1–2. The ignored start does not restart the run.
